// File: rtl/rf_pkg.sv
// Shared definitions for the parametrised register file: default geometry,
// the reset value of general registers and the PC-update priority encoding.
package rf_pkg;

  localparam int unsigned RF_DW     = 32;
  localparam int unsigned RF_NREGS  = 16;
  localparam int unsigned RF_AW     = 4;
  localparam int unsigned RF_PC_IDX = 15;

  localparam logic [RF_DW-1:0] REG_ZERO = '0;

  // Source selected for the next PC value, in priority order.
  typedef enum logic [1:0] {
    PCSEL_HOLD = 2'd0,  // stall, or nothing to load
    PCSEL_PW   = 2'd1,  // redirect: write-port data aimed at the PC index
    PCSEL_PCIN = 2'd2   // sequential advance from the IF adder
  } pcsel_e;

  // A hazard stall beats everything; a redirect beats the sequential load.
  function automatic pcsel_e pc_select(input logic hz_pc_ld,
                                       input logic pc_wr,
                                       input logic pc_ld);
    pcsel_e sel;
    sel = PCSEL_HOLD;
    if (hz_pc_ld) begin
      if (pc_wr) begin
        sel = PCSEL_PW;
      end else if (pc_ld) begin
        sel = PCSEL_PCIN;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/rf_pc_register.sv
// Program-counter register: priority-selected next PC, hazard stall, and a
// one-cycle redirect pulse that tells the pipeline to flush.
module rf_pc_register
  import rf_pkg::*;
#(
  parameter int unsigned     DW       = RF_DW,
  parameter logic [DW-1:0]   RESET_PC = '0
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          hz_pc_ld_i,
  input  logic          pc_wr_i,
  input  logic [DW-1:0] pw_i,
  input  logic          pc_ld_i,
  input  logic [DW-1:0] pc_in_i,
  output logic [DW-1:0] pc_o,
  output logic          redir_o
);

  pcsel_e        pc_sel;
  logic [DW-1:0] pc_d, pc_q;
  logic          redir_d, redir_q;

  // Next-state selection for the PC and the redirect flag.
  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // branch; a path that leaves one unassigned would infer a latch.
    pc_d    = pc_q;
    redir_d = 1'b0;
    pc_sel  = pc_select(hz_pc_ld_i, pc_wr_i, pc_ld_i);
    case (pc_sel)
      PCSEL_PW: begin
        pc_d    = pw_i;
        redir_d = 1'b1;
      end
      PCSEL_PCIN: pc_d = pc_in_i;
      default:    ;
    endcase
  end

  // PC and redirect flops, asynchronously reset to the boot vector.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: state is assigned with <= so every flop samples pre-edge values;
    // a blocking = here would let later statements see the new value.
    if (!rst_ni) begin
      pc_q    <= RESET_PC;
      redir_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      redir_q <= redir_d;
    end
  end

  assign pc_o    = pc_q;
  assign redir_o = redir_q;

endmodule

// File: rtl/param_register_file.sv
// ID-stage register file: NREGS-1 general registers plus an aliased PC,
// three combinational read ports with optional write-through, one write port.
module param_register_file
  import rf_pkg::*;
#(
  parameter int unsigned   DW          = RF_DW,
  parameter int unsigned   NREGS       = RF_NREGS,
  parameter int unsigned   AW          = RF_AW,
  parameter int unsigned   PC_IDX      = RF_PC_IDX,
  parameter logic [DW-1:0] RESET_PC    = '0,
  parameter int unsigned   PC_READ_OFS = 8,
  parameter bit            BYPASS      = 1'b1
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic [AW-1:0] SA,
  input  logic [AW-1:0] SB,
  input  logic [AW-1:0] SD,
  output logic [DW-1:0] PA,
  output logic [DW-1:0] PB,
  output logic [DW-1:0] PD,
  input  logic [AW-1:0] C,
  input  logic [DW-1:0] PW,
  input  logic          RFLd,
  input  logic [DW-1:0] PCin,
  input  logic          PCLd,
  input  logic          HZPCLd,
  output logic [DW-1:0] PCout,
  output logic          PCredir
);

  localparam int NPORTS = 3;

  logic [NREGS-1:0] wr_en;
  logic [DW-1:0]    regs_q [NREGS];
  logic [DW-1:0]    pc_read;
  logic [AW-1:0]    rsel  [NPORTS];
  logic [DW-1:0]    rdata [NPORTS];

  // One-hot write decoder; an unknown C matches no index, so nothing is written.
  always_comb begin
    wr_en = '0;
    if (RFLd) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        if (C == AW'(i)) begin
          wr_en[i] = 1'b1;
        end
      end
    end
  end

  // General register array; the PC slot is never written here.
  always_ff @(posedge CLK or negedge RST_N) begin
    // NOTE: every entry is reset because software relies on registers reading
    // zero after reset; this is why the array is flops rather than a RAM.
    if (!RST_N) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        regs_q[i] <= DW'(REG_ZERO);
      end
    end else begin
      for (int i = 0; i < int'(NREGS); i++) begin
        if (wr_en[i] && (i != int'(PC_IDX))) begin
          regs_q[i] <= PW;
        end
      end
    end
  end

  rf_pc_register #(
    .DW       (DW),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk_i      (CLK),
    .rst_ni     (RST_N),
    .hz_pc_ld_i (HZPCLd),
    .pc_wr_i    (wr_en[PC_IDX]),
    .pw_i       (PW),
    .pc_ld_i    (PCLd),
    .pc_in_i    (PCin),
    .pc_o       (PCout),
    .redir_o    (PCredir)
  );

  // Reads of the PC index see the PC ahead by a fixed offset, wrapping at DW bits.
  assign pc_read = PCout + DW'(PC_READ_OFS);

  assign rsel[0] = SA;
  assign rsel[1] = SB;
  assign rsel[2] = SD;

  // Read muxes: PC alias first, then same-cycle write-through, then storage.
  always_comb begin
    for (int p = 0; p < NPORTS; p++) begin
      rdata[p] = regs_q[rsel[p]];
      if (rsel[p] == AW'(PC_IDX)) begin
        rdata[p] = pc_read;
      end else if (BYPASS && wr_en[rsel[p]]) begin
        rdata[p] = PW;
      end
    end
  end

  assign PA = rdata[0];
  assign PB = rdata[1];
  assign PD = rdata[2];

endmodule

// File: tb/tb_param_register_file.sv
// Self-checking bench: two instances (write-through on and off) driven in
// lockstep and compared against an array-based model of the register file.
module tb_param_register_file;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [3:0]  PCI    = 4'd15;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [3:0]  sa, sb, sd, c;
  logic [31:0] pw, pcin;
  logic        rfld, pcld, hz;

  // Index 1 = write-through instance, index 0 = no write-through.
  logic [31:0] pa [2];
  logic [31:0] pb [2];
  logic [31:0] pd [2];
  logic [31:0] pcout [2];
  logic        redir [2];

  always #5 CLK = ~CLK;

  param_register_file #(.RESET_PC(RST_PC), .BYPASS(1'b1)) u_byp (
    .CLK(CLK), .RST_N(RST_N), .SA(sa), .SB(sb), .SD(sd),
    .PA(pa[1]), .PB(pb[1]), .PD(pd[1]), .C(c), .PW(pw), .RFLd(rfld),
    .PCin(pcin), .PCLd(pcld), .HZPCLd(hz), .PCout(pcout[1]), .PCredir(redir[1])
  );

  param_register_file #(.RESET_PC(RST_PC), .BYPASS(1'b0)) u_nob (
    .CLK(CLK), .RST_N(RST_N), .SA(sa), .SB(sb), .SD(sd),
    .PA(pa[0]), .PB(pb[0]), .PD(pd[0]), .C(c), .PW(pw), .RFLd(rfld),
    .PCin(pcin), .PCLd(pcld), .HZPCLd(hz), .PCout(pcout[0]), .PCredir(redir[0])
  );

  // Reference model state.
  logic [31:0] m_reg [16];
  logic [31:0] m_pc;
  logic        m_redir;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit wr_known();
    return (rfld === 1'b1) && !$isunknown(c);
  endfunction

  function automatic logic [31:0] m_read(input logic [3:0] s, input bit byp);
    if (s == PCI) return m_pc + 32'd8;
    if (byp && wr_known() && c == s) return pw;
    return m_reg[s];
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 16; i++) m_reg[i] = 32'd0;
    m_pc    = RST_PC;
    m_redir = 1'b0;
  endtask

  // Architectural effect of one rising edge with the current inputs.
  task automatic m_edge();
    bit pc_hit;
    pc_hit = wr_known() && (c == PCI);
    if (wr_known() && !pc_hit) m_reg[c] = pw;
    if (!hz) begin
      m_redir = 1'b0;
    end else if (pc_hit) begin
      m_pc    = pw;
      m_redir = 1'b1;
    end else begin
      if (pcld) m_pc = pcin;
      m_redir = 1'b0;
    end
  endtask

  task automatic check_reads();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("PA[%0d] sel=%0d", k, sa), pa[k], m_read(sa, k == 1));
      check($sformatf("PB[%0d] sel=%0d", k, sb), pb[k], m_read(sb, k == 1));
      check($sformatf("PD[%0d] sel=%0d", k, sd), pd[k], m_read(sd, k == 1));
    end
  endtask

  task automatic check_pc();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("PCout[%0d]", k), pcout[k], m_pc);
      check($sformatf("PCredir[%0d]", k), {31'd0, redir[k]}, {31'd0, m_redir});
    end
  endtask

  task automatic idle();
    sa = 4'd0; sb = 4'd0; sd = 4'd0; c = 4'd0; pw = 32'd0;
    rfld = 1'b0; pcld = 1'b0; pcin = 32'd0; hz = 1'b1;
  endtask

  // Inputs were set just after a falling edge: check reads, take the edge, check PC.
  task automatic tick();
    #1 check_reads();
    @(posedge CLK);
    if (RST_N) m_edge();
    #1 check_pc();
  endtask

  initial begin
    idle();
    RST_N = 1'b0;
    m_reset();

    // Reset state: every general register reads zero, PC at the boot vector.
    for (int i = 0; i < 15; i++) begin
      @(negedge CLK); idle(); sa = 4'(i); sb = PCI; sd = 4'(14 - i);
      tick();
    end
    // A write presented during reset must be discarded.
    @(negedge CLK); idle(); rfld = 1'b1; c = 4'd3; pw = 32'hBAD0_BAD0; pcld = 1'b1; pcin = 32'h44;
    tick();
    @(negedge CLK); idle(); sa = 4'd3;
    #2 RST_N = 1'b1;  // released mid-cycle
    tick();

    // First write after reset, visible on the next cycle.
    @(negedge CLK); idle(); rfld = 1'b1; c = 4'd3; pw = 32'h5A;
    tick();
    @(negedge CLK); idle(); sa = 4'd3;
    tick();

    // Write-through versus registered read.
    @(negedge CLK); idle(); rfld = 1'b1; c = 4'd7; pw = 32'hDEAD; sa = 4'd7; sb = 4'd7; sd = 4'd7;
    tick();
    @(negedge CLK); idle(); sa = 4'd7; sb = 4'd7; sd = 4'd7;
    tick();

    // PC read offset, with and without wrap.
    @(negedge CLK); idle(); rfld = 1'b1; c = PCI; pw = 32'hFFFF_FFFC; pcld = 1'b1; pcin = 32'h40;
    tick();
    @(negedge CLK); idle(); sa = PCI; rfld = 1'b1; c = PCI; pw = 32'h20;
    tick();
    @(negedge CLK); idle(); sa = PCI; sb = PCI;
    tick();

    // Sequential advance, two stalled edges, then resume from current PCin.
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK); idle(); pcld = 1'b1; pcin = 32'(4 * i); sa = PCI;
      hz = (i == 3 || i == 4) ? 1'b0 : 1'b1;
      tick();
    end

    // Redirect beats sequential load; pulse lasts one cycle; stall suppresses it.
    @(negedge CLK); idle(); pcld = 1'b1; pcin = 32'h40; rfld = 1'b1; c = PCI; pw = 32'h200;
    tick();
    @(negedge CLK); idle();
    tick();
    @(negedge CLK); idle(); pcld = 1'b1; pcin = 32'h40; rfld = 1'b1; c = PCI; pw = 32'h300; hz = 1'b0;
    tick();
    // Back-to-back redirects keep the pulse high.
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK); idle(); rfld = 1'b1; c = PCI; pw = 32'h400 + 32'(i);
      tick();
    end

    // Unknown write select must not write anything.
    @(negedge CLK); idle(); rfld = 1'b1; c = 'x; pw = 32'hCAFE_F00D; pcld = 1'b1; pcin = 32'h80;
    tick();
    for (int i = 0; i < 15; i += 3) begin
      @(negedge CLK); idle(); sa = 4'(i); sb = 4'(i + 1); sd = 4'(i + 2);
      tick();
    end

    // Stall does not block general writes; then an asynchronous mid-cycle reset.
    @(negedge CLK); idle(); hz = 1'b0; rfld = 1'b1; c = 4'd2; pw = 32'h11; pcld = 1'b1; pcin = 32'h90;
    tick();
    @(negedge CLK); idle(); hz = 1'b0; sa = 4'd2; sb = PCI;
    tick();
    @(negedge CLK); idle(); sa = 4'd2; sb = 4'd3; sd = PCI;
    #2 RST_N = 1'b0;
    m_reset();
    #1 check_reads();
    check_pc();
    #1 RST_N = 1'b1;

    // Randomised traffic.
    for (int n = 0; n < 400; n++) begin
      @(negedge CLK);
      sa   = 4'($urandom_range(0, 15));
      sb   = 4'($urandom_range(0, 15));
      sd   = 4'($urandom_range(0, 15));
      c    = ($urandom_range(0, 3) == 0) ? PCI : 4'($urandom_range(0, 15));
      if ($urandom_range(0, 39) == 0) c = 'x;
      pw   = $urandom();
      rfld = 1'($urandom_range(0, 1));
      pcld = ($urandom_range(0, 9) < 7);
      pcin = $urandom();
      hz   = ($urandom_range(0, 9) < 8);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
